// File: rtl/lut4_sweep_pkg.sv
// Shared types and sizes for the LUT4 sweep checker.
package lut4_sweep_pkg;

  localparam int unsigned SWEEP_LEN = 16;
  localparam int unsigned IDX_W     = 4;
  localparam int unsigned CNT_W     = 5;
  localparam int unsigned SETTLE_W  = 8;

  typedef enum logic [2:0] {
    StIdle,
    StDrive,
    StSettle,
    StSample,
    StDone
  } state_e;

endpackage

// File: rtl/lut4_sweep_settle_cnt.sv
// Loadable down-counter with zero flag; times the settle window per code.
module lut4_sweep_settle_cnt
  import lut4_sweep_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [SETTLE_W-1:0] load_val,
  input  logic                dec,
  output logic                zero
);

  logic [SETTLE_W-1:0] cnt_q;

  // Load takes priority; decrement stops at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/lut4_sweep_checker.sv
// LUT4 sweep checker: drives all 16 input codes, waits a settle time, samples the
// LUT output and compares against EXPECT. Optional truth-table capture into
// `observed` is enabled by defining LUT4_SWEEP_CAPTURE_EN.
module lut4_sweep_checker
  import lut4_sweep_pkg::*;
#(
  parameter logic [SWEEP_LEN-1:0] EXPECT        = 16'hFF5F,
  parameter int unsigned          SETTLE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic [IDX_W-1:0]     lut_i,
  input  logic                 lut_o,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [CNT_W-1:0]     err_cnt,
  output logic [IDX_W-1:0]     first_err,
  output logic [SWEEP_LEN-1:0] observed
);

  localparam logic [SETTLE_W-1:0] SettleLoad = SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [IDX_W-1:0]    LastIdx    = IDX_W'(SWEEP_LEN - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [IDX_W-1:0] first_q, first_d;
  logic             cnt_load, cnt_dec, cnt_zero;
  logic             mismatch;

  // X/Z on lut_o must count as a mismatch, hence case equality.
  assign mismatch = !(lut_o === EXPECT[idx_q]);

  lut4_sweep_settle_cnt u_settle_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (SettleLoad),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // State and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      err_q   <= '0;
      first_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      first_q <= first_d;
    end
  end

  // Next-state logic; the index register doubles as the LUT input drive.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    err_d    = err_q;
    first_d  = first_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StDrive;
          idx_d   = '0;
          err_d   = '0;
          first_d = '0;
        end
      end
      StDrive: begin
        cnt_load = 1'b1;
        state_d  = StSettle;
      end
      StSettle: begin
        if (cnt_zero) begin
          state_d = StSample;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      StSample: begin
        if (mismatch) begin
          err_d = err_q + 1'b1;
          if (err_q == '0) begin
            first_d = idx_q;
          end
        end
        if (idx_q == LastIdx) begin
          state_d = StDone;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = StDrive;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign lut_i     = idx_q;
  assign busy      = (state_q == StDrive) || (state_q == StSettle) || (state_q == StSample);
  assign done      = (state_q == StDone);
  assign pass      = done && (err_q == '0);
  assign err_cnt   = err_q;
  assign first_err = first_q;

`ifdef LUT4_SWEEP_CAPTURE_EN
  logic [SWEEP_LEN-1:0] obs_q;
  logic                 obs_clr, obs_wr;

  assign obs_clr = start && ((state_q == StIdle) || (state_q == StDone));
  assign obs_wr  = (state_q == StSample);

  // Capture the sampled LUT output into its code position.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      obs_q <= '0;
    end else if (obs_clr) begin
      obs_q <= '0;
    end else if (obs_wr) begin
      obs_q[idx_q] <= lut_o;
    end
  end

  assign observed = obs_q;
`else
  assign observed = '0;
`endif

endmodule

// File: tb/tb_lut4_sweep_checker.sv
// Self-checking bench for lut4_sweep_checker with a behavioural LUT model.
module tb_lut4_sweep_checker;

  localparam logic [15:0] EXP_TT = 16'hFF5F;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        start2 = 1'b0;
  logic [15:0] tt = EXP_TT;
  logic [3:0]  lut_i, lut_i2;
  logic        lut_o, lut_o2;
  logic        busy, done, pass, busy2, done2, pass2;
  logic [4:0]  err_cnt, err_cnt2;
  logic [3:0]  first_err, first_err2;
  logic [15:0] observed, observed2;

  int n_cmp = 0;
  int n_err = 0;

  // Reference results
  int          m_err;
  int          m_first;
  logic        m_pass;
  logic [15:0] m_obs;

  always #5 clk = ~clk;

  // Behavioural LUT under test: a truth table lookup.
  assign lut_o  = tt[lut_i];
  assign lut_o2 = EXP_TT[lut_i2];

  lut4_sweep_checker #(.EXPECT(EXP_TT), .SETTLE_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .lut_i(lut_i), .lut_o(lut_o),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
    .first_err(first_err), .observed(observed)
  );

  lut4_sweep_checker #(.EXPECT(EXP_TT), .SETTLE_CYCLES(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .lut_i(lut_i2), .lut_o(lut_o2),
    .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err_cnt2),
    .first_err(first_err2), .observed(observed2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected results straight from the rules: count differing codes, note the lowest.
  task automatic model(input logic [15:0] table_v);
    m_err   = 0;
    m_first = 0;
    for (int c = 0; c < 16; c++) begin
      if (table_v[c] != EXP_TT[c]) begin
        if (m_err == 0) m_first = c;
        m_err++;
      end
    end
    m_pass = (m_err == 0);
`ifdef LUT4_SWEEP_CAPTURE_EN
    m_obs = table_v;
`else
    m_obs = 16'h0000;
`endif
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 2000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".lut_i"}, 32'(lut_i), 0);
    check({tag, ".busy"}, 32'(busy), 0);
    check({tag, ".done"}, 32'(done), 0);
    check({tag, ".pass"}, 32'(pass), 0);
    check({tag, ".err_cnt"}, 32'(err_cnt), 0);
    check({tag, ".first_err"}, 32'(first_err), 0);
    check({tag, ".observed"}, 32'(observed), 0);
  endtask

  task automatic check_result(input string tag);
    check({tag, ".busy"}, 32'(busy), 0);
    check({tag, ".pass"}, 32'(pass), 32'(m_pass));
    check({tag, ".err_cnt"}, 32'(err_cnt), 32'(m_err));
    if (!m_pass) check({tag, ".first_err"}, 32'(first_err), 32'(m_first));
    check({tag, ".observed"}, 32'(observed), 32'(m_obs));
  endtask

  task automatic sweep(input logic [15:0] table_v, input string tag);
    int cyc;
    tt = table_v;
    model(table_v);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    check({tag, ".busy_rise"}, 32'(busy), 1);
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc);
    check({tag, ".latency"}, 32'(cyc), 96);
    check_result(tag);
    repeat (3) @(negedge clk);
    check({tag, ".hold_done"}, 32'(done), 1);
    check_result({tag, ".hold"});
  endtask

  initial begin
    int cyc;
    repeat (2) @(negedge clk);
    check_reset("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset("idle");

    sweep(16'hFF5F, "match");
    sweep(16'hFF7F, "code5");
    sweep(16'h00A0, "inverted");
    for (int r = 0; r < 4; r++) sweep(16'($urandom), "random");

    // Reset mid-sweep, 40 cycles in: partial errors must vanish.
    tt = 16'hFF7F;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (39) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset("abort");
    @(posedge clk);
    #1;
    check_reset("abort_next");
    @(negedge clk);
    rst_n = 1'b1;
    sweep(16'hFF5F, "after_abort");

    // Start held high: ignored mid-sweep, then immediate restart from DONE.
    tt = 16'hFF5F;
    model(tt);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    wait_done(cyc);
    check("held.latency1", 32'(cyc), 96);
    check_result("held1");
    @(posedge clk);
    #1;
    check("held.restart_done", 32'(done), 0);
    check("held.restart_busy", 32'(busy), 1);
    wait_done(cyc);
    check("held.latency2", 32'(cyc), 96);
    check_result("held2");
    @(negedge clk);
    start = 1'b0;

    // Short settle instance: 16 x 3 cycles.
    @(negedge clk);
    start2 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start2 = 1'b0;
    cyc = 1;
    while (!done2 && cyc < 2000) begin
      @(posedge clk);
      #1;
      if (!done2) cyc++;
    end
    check("settle1.latency", 32'(cyc), 48);
    check("settle1.pass", 32'(pass2), 1);
    check("settle1.err_cnt", 32'(err_cnt2), 0);
`ifdef LUT4_SWEEP_CAPTURE_EN
    check("settle1.observed", 32'(observed2), 32'(EXP_TT));
`else
    check("settle1.observed", 32'(observed2), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
